sm_mem_arbiter: RTL and testbench

//  Shares one single-port memory between the CPU instruction-fetch port (I) and data load/store port (D).
//  One transaction in flight at a time: arbitrate, capture, issue to memory, route response to owner.

---
 rtl/sm_mem_arbiter_pkg.sv | 16 +
 rtl/sm_mem_arbiter_pick.sv | 28 ++
 rtl/sm_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_sm_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Round-robin arbitration is enabled with the SM_ARB_RR_EN macro.
package sm_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arbState_t;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arbOwner_t;

endpackage

// File: rtl/sm_mem_arbiter_pick.sv
// Combinational two-way picker between fetch and data requests.
// SM_ARB_RR_EN selects round-robin; otherwise the data port has fixed priority.
module sm_arb_pick
  import sm_mem_arbiter_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
`ifdef SM_ARB_RR_EN
  input  arbOwner_t last_owner,
`endif
  output logic      pick_valid,
  output arbOwner_t pick_owner
);

  always_comb begin
    pick_valid = i_req | d_req;
`ifdef SM_ARB_RR_EN
    // On a tie the port that did not win last time gets the grant.
    if (i_req && d_req)
      pick_owner = (last_owner == ARB_OWN_I) ? ARB_OWN_D : ARB_OWN_I;
    else
      pick_owner = d_req ? ARB_OWN_D : ARB_OWN_I;
`else
    pick_owner = d_req ? ARB_OWN_D : ARB_OWN_I;
`endif
  end

endmodule

// File: rtl/sm_mem_arbiter.sv
// Shares one single-port memory between CPU fetch (I) and load/store (D) ports.
// Define SM_ARB_RR_EN for round-robin arbitration; default is D-over-I priority.
module sm_mem_arbiter
  import sm_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arbState_t state;
  arbOwner_t owner;
  logic      pickValid;
  arbOwner_t pickOwner;
  logic      grantNow;

`ifdef SM_ARB_RR_EN
  arbOwner_t lastOwner;
`endif

  sm_arb_pick picker (
    .i_req      (i_req),
    .d_req      (d_req),
`ifdef SM_ARB_RR_EN
    .last_owner (lastOwner),
`endif
    .pick_valid (pickValid),
    .pick_owner (pickOwner)
  );

  // Grants are same-cycle so the requester can release its request at the next edge.
  assign grantNow = !rst && (state == ARB_IDLE) && pickValid;
  assign i_gnt    = grantNow && (pickOwner == ARB_OWN_I);
  assign d_gnt    = grantNow && (pickOwner == ARB_OWN_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= ARB_OWN_I;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
`ifdef SM_ARB_RR_EN
      lastOwner <= ARB_OWN_I;
`endif
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pickValid) begin
            owner   <= pickOwner;
            mem_req <= 1'b1;
            state   <= ARB_ISSUE;
`ifdef SM_ARB_RR_EN
            lastOwner <= pickOwner;
`endif
            if (pickOwner == ARB_OWN_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_we ? ARB_IDLE : ARB_WAIT;
          end
        end
        // Only the owner sees the response; the other port's rdata keeps its old value.
        ARB_WAIT: begin
          if (mem_rvalid) begin
            if (owner == ARB_OWN_D) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              i_rdata  <= mem_rdata;
              i_rvalid <= 1'b1;
            end
            state <= ARB_IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Directed self-checking bench for sm_mem_arbiter; the bench plays the memory.
// Tie-break expectations follow SM_ARB_RR_EN when it is defined.
module tb_sm_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  sm_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b1;
    #1;
    checks++;
    if (i_gnt !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_gnt_block: i_gnt=%0b want 0", i_gnt);
    end
    i_req = 1'b0;
    doReset();
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b want 000000",
                         {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
      errors++; $display("[TB] FAIL reset_data: got %h want 0",
                         {mem_addr, mem_wdata, i_rdata, d_rdata});
    end
    checks++;
    if (dut.state !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_state: got %0d want 0", dut.state);
    end
  endtask

  task automatic test_fetch_read();
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    checks++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      errors++; $display("[TB] FAIL fetch_gnt: got %b want 10", {i_gnt, d_gnt});
    end
    tick();
    i_req = 1'b0; mem_gnt = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
      errors++; $display("[TB] FAIL fetch_issue: req=%0b we=%0b addr=%h want 1 0 10",
                         mem_req, mem_we, mem_addr);
    end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (mem_req !== 1'b0 || i_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL fetch_wait: mem_req=%0b i_rvalid=%0b want 0 0", mem_req, i_rvalid);
    end
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("[TB] FAIL fetch_resp: rv=%b rdata=%h want 10 deadbeef",
                         {i_rvalid, d_rvalid}, i_rdata);
    end
    tick();
    checks++;
    if (i_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL fetch_pulse: i_rvalid=%0b want 0", i_rvalid);
    end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
    #1;
    checks++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      errors++; $display("[TB] FAIL store_gnt: got %b want 01", {i_gnt, d_gnt});
    end
    tick();
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'h55}) begin
        errors++; $display("[TB] FAIL store_hold%0d: req=%0b we=%0b addr=%h wdata=%h want 1 1 20 55",
                           c, mem_req, mem_we, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({mem_req, d_rvalid, i_rvalid} !== 3'b000 || dut.state !== 2'd0) begin
        errors++; $display("[TB] FAIL store_done%0d: req/drv/irv=%b state=%0d want 000 0",
                           c, {mem_req, d_rvalid, i_rvalid}, dut.state);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] expD;
    logic       wantD;
`ifdef SM_ARB_RR_EN
    expD = 4'b0101;
`else
    expD = 4'b1111;
`endif
    doReset();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    #1;
    for (int k = 0; k < 4; k++) begin
      wantD = expD[k];
      checks++;
      if ({i_gnt, d_gnt} !== {!wantD, wantD}) begin
        errors++; $display("[TB] FAIL b2b_gnt%0d: got %b want %b", k, {i_gnt, d_gnt}, {!wantD, wantD});
      end
      tick();
      mem_gnt = 1'b1;
      #1;
      checks++;
      if ({i_gnt, d_gnt, mem_req} !== 3'b001 || mem_addr !== (wantD ? 32'h200 : 32'h100)) begin
        errors++; $display("[TB] FAIL b2b_issue%0d: gnt/req=%b addr=%h want 001 %h", k,
                           {i_gnt, d_gnt, mem_req}, mem_addr, wantD ? 32'h200 : 32'h100);
      end
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0 + k;
      tick();
      mem_rvalid = 1'b0;
      #1;
      checks++;
      if ({i_rvalid, d_rvalid} !== {!wantD, wantD} ||
          (wantD ? d_rdata : i_rdata) !== 32'hA0 + k) begin
        errors++; $display("[TB] FAIL b2b_resp%0d: rv=%b i=%h d=%h want %b data %h", k,
                           {i_rvalid, d_rvalid}, i_rdata, d_rdata, {!wantD, wantD}, 32'hA0 + k);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    i_req = 1'b1; i_addr = 32'h30;
    tick();
    i_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    tick();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({i_rvalid, d_rvalid, mem_req, mem_we} !== 4'b0 || {mem_addr, i_rdata, d_rdata} !== 96'h0 ||
          dut.state !== 2'd0) begin
        errors++; $display("[TB] FAIL abort%0d: rv/req/we=%b addr=%h ird=%h drd=%h state=%0d want 0",
                           c, {i_rvalid, d_rvalid, mem_req, mem_we}, mem_addr, i_rdata, d_rdata, dut.state);
      end
      tick();
    end
  endtask

  task automatic test_stray();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if ({i_rvalid, d_rvalid, mem_req} !== 3'b000 || dut.state !== 2'd0) begin
      errors++; $display("[TB] FAIL stray_rvalid: rv/req=%b state=%0d want 000 0",
                         {i_rvalid, d_rvalid, mem_req}, dut.state);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    tick();
    d_req = 1'b0; mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    #1;
    checks++;
    if (dut.state !== 2'd2 || mem_req !== 1'b0 || d_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL stray_gnt: state=%0d req=%0b drv=%0b want 2 0 0",
                         dut.state, mem_req, d_rvalid);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if ({i_rvalid, d_rvalid, d_rdata} !== {2'b01, 32'hCAFE} || dut.state !== 2'd0) begin
      errors++; $display("[TB] FAIL stray_resp: rv=%b d_rdata=%h state=%0d want 01 cafe 0",
                         {i_rvalid, d_rvalid}, d_rdata, dut.state);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_store();
    test_back_to_back();
    test_reset_abort();
    test_stray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
